list_range_producer: RTL
========================

// Module: list_range_producer
// PURPOSE
//   Producer (responder) end of the lazy list stream: answers req with ack/value/eol.
//   Generates the inclusive arithmetic range [start_val, start_val+step_val, .. end_val]
//   (Haskell enumFromThenTo semantics), one element per request.
//   Instantiated as a dfd_* list-returning function body, driven by consumer logic.
//   Uses the ready/done call convention of the compiled functions.
// PARAMETERS
//   WIDTH      8    bit width of start_val/end_val/step_val/value (two's complement)
//   CNT_WIDTH  16   width of elem_count (only with LIST_RANGE_COUNT_EN)
// PORTS
//   clock       in   1          rising-edge clock
//   reset       in   1          synchronous, active-high reset
//   ready       in   1          call active; args valid while high
//   done        out  1          list handle valid; elements may be requested
//   start_val   in   WIDTH      first element, signed
//   end_val     in   WIDTH      inclusive bound, signed
//   step_val    in   WIDTH      increment, signed (may be negative or zero)
//   req         in   1          consumer requests next element (level)
//   ack         out  1          one-cycle pulse: value/eol valid this cycle
//   eol         out  1          end of list; qualifies ack
//   value       out  WIDTH      element; 0 when eol
//   elem_count  out  CNT_WIDTH  elements acked so far (LIST_RANGE_COUNT_EN only)
// BEHAVIOUR
//   Reset: done=0, ack=0, eol=0, value=0, elem_count=0, state=IDLE. Reset wins over all.
//   All outputs registered. States: IDLE, ARMED, ACKED, EXHAUSTED.
//   IDLE: ready sampled high -> latch start/end/step into regs, cur<=start_val,
//     compute empty flag -> ARMED (or EXHAUSTED if empty); done=1 from next cycle.
//   Empty: step>=0 and start>end, or step<0 and start<end.
//   ARMED: req sampled high at edge N -> ack=1 in cycle after N, value=cur, eol=0;
//     cur<=cur+step -> ACKED. Latency: exactly one cycle from req sample to ack.
//   ACKED: ack cleared; req ignored until sampled low once (one ack per req assertion);
//     after req low -> ARMED, or EXHAUSTED if the next element is out of range.
//   Range test on next: step>0 -> next>end; step<0 -> next<end; step==0 -> never
//     (infinite list of start_val).
//   Overflow: next computed in WIDTH+1 bits; any result outside signed WIDTH range
//     counts as out of range (no wrap-around elements ever emitted).
//   EXHAUSTED: every new req -> ack=1, eol=1, value=0; same req-low rule as ACKED;
//     remains until ready drops.
//   ready sampled low in any non-IDLE state -> IDLE next cycle: done=0, ack=0, eol=0,
//     pending req discarded; a request coincident with ready falling is not acked.
//   Args are ignored after latching; changes while ready stays high have no effect.
//   req while done=0 is ignored (not queued).
// CONFIGURATION
//   LIST_RANGE_COUNT_EN defined: elem_count increments on each ack with eol=0,
//     saturates at all-ones, clears on reset and on entry to IDLE.
//   Undefined: elem_count port and counter absent; behaviour otherwise identical.
// TESTING
//   start=-2,end=4,step=1, ready=1, 8 req pulses -> values -2,-1,0,1,2,3,4 then eol=1,value=0.
//   start=10,end=1,step=-3 -> 10,7,4,1 then eol; start=1,end=0,step=1 -> first ack has eol=1.
//   WIDTH=8, start=120,end=127,step=5 -> 120,125 then eol (no wrap to negative).
//   step=0,start=3 -> 20 consecutive acks all value=3, eol=0; elem_count=20 when _EN set.
//   req held high 10 cycles -> exactly one ack; ack asserted exactly one cycle after req sample.
//   reset or ready low mid-list (after 3 elements) -> done/ack/eol=0 next cycle; new call restarts at start.

Source files
------------

// File: rtl/list_range_producer.sv
// Producer end of a lazy list stream: answers req with ack/value/eol for the inclusive range
// start_val, start_val+step_val, .. end_val. Optional element counter: define LIST_RANGE_COUNT_EN.
module list_range_producer #(
  parameter int WIDTH = 8
`ifdef LIST_RANGE_COUNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ready,
  output logic             done,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic [WIDTH-1:0] step_val,
  input  logic             req,
  output logic             ack,
  output logic             eol,
  output logic [WIDTH-1:0] value
`ifdef LIST_RANGE_COUNT_EN
  , output logic [CNT_WIDTH-1:0] elem_count
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, ACKED, EXHAUSTED} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] cur;
  logic signed [WIDTH-1:0] end_r;
  logic signed [WIDTH-1:0] step_r;
  logic                    last;

  logic signed [WIDTH:0]   cur_w;
  logic signed [WIDTH:0]   step_w;
  logic signed [WIDTH:0]   end_w;
  logic signed [WIDTH:0]   next_w;
  logic                    next_out;
  logic                    args_empty;

  // The WIDTH+1 sum is exact, so an overflowing next element always lands beyond end_r
  // and is rejected by the bound compare; no wrapped value is ever emitted.
  always_comb begin
    cur_w    = {cur[WIDTH-1], cur};
    step_w   = {step_r[WIDTH-1], step_r};
    end_w    = {end_r[WIDTH-1], end_r};
    next_w   = cur_w + step_w;
    next_out = 1'b0;
    if (step_r[WIDTH-1])
      next_out = (next_w < end_w);
    else if (step_r != '0)
      next_out = (next_w > end_w);
  end

  always_comb begin
    args_empty = step_val[WIDTH-1] ? ($signed(start_val) < $signed(end_val))
                                   : ($signed(start_val) > $signed(end_val));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      ack    <= 1'b0;
      eol    <= 1'b0;
      value  <= '0;
      cur    <= '0;
      end_r  <= '0;
      step_r <= '0;
      last   <= 1'b0;
`ifdef LIST_RANGE_COUNT_EN
      elem_count <= '0;
`endif
    end else if (state != IDLE && !ready) begin
      state <= IDLE;
      done  <= 1'b0;
      ack   <= 1'b0;
      eol   <= 1'b0;
      value <= '0;
`ifdef LIST_RANGE_COUNT_EN
      elem_count <= '0;
`endif
    end else begin
      ack   <= 1'b0;
      eol   <= 1'b0;
      value <= '0;
      case (state)
        IDLE: begin
          if (ready) begin
            cur    <= start_val;
            end_r  <= end_val;
            step_r <= step_val;
            last   <= args_empty;
            done   <= 1'b1;
            state  <= args_empty ? EXHAUSTED : ARMED;
          end
        end
        ARMED: begin
          if (req) begin
            ack   <= 1'b1;
            value <= cur;
            cur   <= next_w[WIDTH-1:0];
            last  <= next_out;
            state <= ACKED;
`ifdef LIST_RANGE_COUNT_EN
            if (elem_count != '1)
              elem_count <= elem_count + CNT_WIDTH'(1);
`endif
          end
        end
        // One ack per req assertion: wait for req to be seen low before re-arming.
        ACKED: begin
          if (!req)
            state <= last ? EXHAUSTED : ARMED;
        end
        EXHAUSTED: begin
          if (req) begin
            ack   <= 1'b1;
            eol   <= 1'b1;
            state <= ACKED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
